dst_reg_scoreboard: RTL and testbench

DST_REG_SCOREBOARD -- requirements
Module: dst_reg_scoreboard

---
 rtl/mips_sb_pkg.sv | 6 +
 rtl/dst_reg_scoreboard_decoder5to32.sv | 13 +
 rtl/dst_reg_scoreboard.sv | 86 ++++++++
 tb/tb_dst_reg_scoreboard.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_sb_pkg.sv
// Shared sizing constants for the destination-register scoreboard.
package mips_sb_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int CNT_W      = 6;
endpackage

// File: rtl/dst_reg_scoreboard_decoder5to32.sv
// 5-bit register address to 32-bit one-hot decoder with enable.
module decoder5to32
    import mips_sb_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] addr,
    input  logic                  en,
    output logic [NUM_REGS-1:0]   onehot
);
    always_comb begin
        onehot = '0;
        if (en) onehot[addr] = 1'b1;
    end
endmodule

// File: rtl/dst_reg_scoreboard.sv
// Destination-register pending scoreboard with WAW stall and source busy checks.
// Optional same-cycle write-back bypass is enabled by defining SB_WB_BYPASS_EN.
module dst_reg_scoreboard
    import mips_sb_pkg::*;
#(
    parameter bit ZERO_HARDWIRED = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  issue_ready,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    output logic                  rs_busy,
    output logic                  rt_busy,
    output logic [NUM_REGS-1:0]   pending,
    output logic [CNT_W-1:0]      pending_cnt,
    output logic                  err_spurious
);
    logic                issue_fire;
    logic                set_en;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] wb_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic                set_any;
    logic                clr_any;
    logic                wb_hit;

`ifdef SB_WB_BYPASS_EN
    always_comb begin
        issue_ready = ~pending[issue_rd] | (wb_valid & (wb_rd == issue_rd));
        rs_busy     = pending[rs] & ~(wb_valid & (wb_rd == rs));
        rt_busy     = pending[rt] & ~(wb_valid & (wb_rd == rt));
    end
`else
    always_comb begin
        issue_ready = ~pending[issue_rd];
        rs_busy     = pending[rs];
        rt_busy     = pending[rt];
    end
`endif

    assign issue_fire = issue_valid & issue_ready;
    // Register 0 issues are accepted but never tracked when it is hardwired.
    assign set_en     = issue_fire & ~(ZERO_HARDWIRED & (issue_rd == '0));

    decoder5to32 u_dec_issue (
        .addr   (issue_rd),
        .en     (set_en),
        .onehot (set_vec)
    );

    decoder5to32 u_dec_wb (
        .addr   (wb_rd),
        .en     (wb_valid),
        .onehot (wb_vec)
    );

    assign wb_hit  = wb_valid & pending[wb_rd];
    assign clr_vec = wb_vec & pending;
    assign set_any = |set_vec;
    assign clr_any = |clr_vec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending      <= '0;
            pending_cnt  <= '0;
            err_spurious <= 1'b0;
        end else begin
            if (wb_valid && !wb_hit) err_spurious <= 1'b1;
            if (flush) begin
                pending     <= '0;
                pending_cnt <= '0;
            end else begin
                // Clear before set so a same-register write-back plus issue stays pending.
                pending     <= (pending & ~clr_vec) | set_vec;
                pending_cnt <= pending_cnt + {{(CNT_W-1){1'b0}}, set_any}
                                           - {{(CNT_W-1){1'b0}}, clr_any};
            end
        end
    end
endmodule

// File: tb/tb_dst_reg_scoreboard.sv
// Self-checking bench for dst_reg_scoreboard: directed scenarios plus random traffic vs a reference model.
module tb_dst_reg_scoreboard;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        issue_ready;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [4:0]  rs = '0;
    logic [4:0]  rt = '0;
    logic        rs_busy;
    logic        rt_busy;
    logic [31:0] pending;
    logic [5:0]  pending_cnt;
    logic        err_spurious;

`ifdef SB_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;

    bit m_pend [32];
    bit m_err;

    dst_reg_scoreboard #(.ZERO_HARDWIRED(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_ready  (issue_ready),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .rs           (rs),
        .rt           (rt),
        .rs_busy      (rs_busy),
        .rt_busy      (rt_busy),
        .pending      (pending),
        .pending_cnt  (pending_cnt),
        .err_spurious (err_spurious)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic int model_cnt();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    function automatic bit model_busy(input logic [4:0] src);
        return m_pend[src] && !(BYP && wb_valid && wb_rd == src);
    endfunction

    function automatic bit model_ready();
        return !m_pend[issue_rd] || (BYP && wb_valid && wb_rd == issue_rd);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".pending"}, pending, model_vec());
        chk({tag, ".cnt"}, 32'(pending_cnt), 32'(model_cnt()));
        chk({tag, ".err"}, 32'(err_spurious), 32'(m_err));
    endtask

    // One clock: drive inputs, check combinational outputs, advance model and DUT, check state.
    task automatic cycle(input string tag, input bit iv, input logic [4:0] ird, input bit wv,
                         input logic [4:0] wrd, input bit fl, input logic [4:0] s, input logic [4:0] t);
        bit fire;
        issue_valid = iv; issue_rd = ird; wb_valid = wv; wb_rd = wrd;
        flush = fl; rs = s; rt = t;
        #1;
        chk({tag, ".ready"}, 32'(issue_ready), 32'(model_ready()));
        chk({tag, ".rs_busy"}, 32'(rs_busy), 32'(model_busy(s)));
        chk({tag, ".rt_busy"}, 32'(rt_busy), 32'(model_busy(t)));
        fire = iv && model_ready();
        if (wv) begin
            if (m_pend[wrd]) begin
                if (!fl) m_pend[wrd] = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end
        if (fl) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
        end else if (fire && ird != 5'd0) begin
            m_pend[ird] = 1'b1;
        end
        @(posedge clk);
        #1;
        issue_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0;
        check_state(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_err = 1'b0;
        check_state("reset");
        issue_rd = 5'd13; rs = 5'd13; rt = 5'd2;
        #1;
        chk("reset.ready", 32'(issue_ready), 32'd1);
        chk("reset.rs_busy", 32'(rs_busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [4:0] ird, wrd, s, t;
        bit iv, wv, fl;
        int off;

        @(posedge clk);
        #1;
        do_reset();

        // Single issue to r5 becomes visible next cycle.
        cycle("iss5", 1, 5'd5, 0, 5'd0, 0, 5'd5, 5'd0);
        chk("iss5.vec", pending, 32'h0000_0020);
        chk("iss5.cnt1", 32'(pending_cnt), 32'd1);
        rs = 5'd5; #1;
        chk("iss5.rs_busy", 32'(rs_busy), 32'd1);

        // WAW stall on r5, then write-back clears it.
        issue_valid = 1'b1; issue_rd = 5'd5; #1;
        chk("waw5.ready", 32'(issue_ready), 32'd0);
        cycle("waw5", 1, 5'd5, 0, 5'd0, 0, 5'd5, 5'd5);
        cycle("wb5", 0, 5'd0, 1, 5'd5, 0, 5'd5, 5'd0);
        chk("wb5.vec", pending, 32'h0);
        chk("wb5.cnt0", 32'(pending_cnt), 32'd0);

        // r0 issue is accepted without marking.
        issue_valid = 1'b1; issue_rd = 5'd0; #1;
        chk("r0.ready", 32'(issue_ready), 32'd1);
        cycle("r0", 1, 5'd0, 0, 5'd0, 0, 5'd0, 5'd0);
        chk("r0.vec", pending, 32'h0);

        // Same-cycle issue and write-back to pending r7.
        cycle("iss7", 1, 5'd7, 0, 5'd0, 0, 5'd7, 5'd0);
        issue_valid = 1'b1; issue_rd = 5'd7; wb_valid = 1'b1; wb_rd = 5'd7; #1;
        chk("byp7.ready", 32'(issue_ready), BYP ? 32'd1 : 32'd0);
        cycle("byp7", 1, 5'd7, 1, 5'd7, 0, 5'd7, 5'd7);
        chk("byp7.vec", pending, BYP ? 32'h0000_0080 : 32'h0);
        if (pending_cnt != 6'd0) cycle("clr7", 0, 5'd0, 1, 5'd7, 0, 5'd0, 5'd0);

        // Spurious write-back sets a sticky error that survives flush.
        cycle("spur9", 0, 5'd0, 1, 5'd9, 0, 5'd9, 5'd0);
        chk("spur9.err", 32'(err_spurious), 32'd1);
        cycle("fl_err", 0, 5'd0, 0, 5'd0, 1, 5'd0, 5'd0);
        chk("fl_err.err", 32'(err_spurious), 32'd1);

        // Fill r1..r31, then flush with a concurrent write-back.
        for (int r = 1; r < 32; r++) cycle("fill", 1, 5'(r), 0, 5'd0, 0, 5'(r), 5'd0);
        chk("fill.cnt31", 32'(pending_cnt), 32'd31);
        chk("fill.vec", pending, 32'hFFFF_FFFE);
        cycle("flush_wb3", 0, 5'd0, 1, 5'd3, 1, 5'd3, 5'd4);
        chk("flush_wb3.cnt0", 32'(pending_cnt), 32'd0);

        do_reset();
        chk("rst.err_clear", 32'(err_spurious), 32'd0);

        // Random traffic; write-backs mostly target pending registers.
        for (int n = 0; n < 400; n++) begin
            iv = ($urandom_range(0, 3) != 0);
            ird = 5'($urandom_range(0, 31));
            wv = ($urandom_range(0, 1) != 0);
            wrd = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) != 0) begin
                off = $urandom_range(0, 31);
                for (int k = 0; k < 32; k++)
                    if (m_pend[(off + k) % 32]) begin
                        wrd = 5'((off + k) % 32);
                        break;
                    end
            end
            fl = ($urandom_range(0, 49) == 0);
            s = 5'($urandom_range(0, 31));
            t = ($urandom_range(0, 3) == 0) ? wrd : 5'($urandom_range(0, 31));
            cycle("rand", iv, ird, wv, wrd, fl, s, t);
        end

        // Asynchronous reset mid-operation discards outstanding state.
        for (int r = 10; r < 14; r++) cycle("pre_rst", 1, 5'(r), 0, 5'd0, 0, 5'd0, 5'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst.vec", pending, 32'h0);
        chk("async_rst.cnt", 32'(pending_cnt), 32'd0);
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_err = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle("post_rst", 1, 5'd12, 0, 5'd0, 0, 5'd12, 5'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
